// File: rtl/hynoc_ingress_ctrl_if.sv
// FIFO-read and egress request/write/data bundle of one hynoc ingress port.
// master is the ingress controller's view; slave is the FIFO/egress side.
interface hynoc_ingress_ctrl_if #(
    parameter int NB_PORTS      = 5,
    parameter int PAYLOAD_WIDTH = 32
);
    localparam int FLIT_WIDTH = PAYLOAD_WIDTH + 1;
    localparam int EG_W       = NB_PORTS - 1;

    logic [FLIT_WIDTH-1:0] rdata;
    logic                  rempty;
    logic                  ren;
    logic [EG_W-1:0]       to_egress_request;
    logic [EG_W-1:0]       to_egress_write;
    logic [FLIT_WIDTH-1:0] to_egress_data;
    logic [EG_W-1:0]       from_egress_grant;
    logic [EG_W-1:0]       from_egress_afull;

    modport master (
        input  rdata, rempty, from_egress_grant, from_egress_afull,
        output ren, to_egress_request, to_egress_write, to_egress_data
    );

    modport slave (
        output rdata, rempty, from_egress_grant, from_egress_afull,
        input  ren, to_egress_request, to_egress_write, to_egress_data
    );
endinterface

// File: rtl/hynoc_ingress_ctrl.sv
// Ingress packet controller: decodes the source route of each header flit,
// requests the egress port and forwards the packet with the route rewritten.
//
// state | meaning
// IDLE  | wait for a header at the FIFO head and decode its route field
// SEND  | request held; pop and forward flits while granted and not afull
// DROP  | route out of range; discard flits up to and including the stop flit
// GUARD | post-packet gap so the egress arbiter sees the request drop
module hynoc_ingress_ctrl #(
    parameter int NB_PORTS      = 5,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                 router_clk,
    input  logic                 router_arst_n,
    hynoc_ingress_ctrl_if.master bus,
    output logic [15:0]          drop_count
);
    localparam int FLIT_WIDTH = PAYLOAD_WIDTH + 1;
    localparam int EG_W       = NB_PORTS - 1;
    localparam int ROUTE_BITS = $clog2(NB_PORTS - 1);
    localparam int GCW        = $clog2(GUARD_CYCLES + 1);
    localparam logic [ROUTE_BITS:0] NB_EGRESS = (ROUTE_BITS + 1)'(EG_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DROP,
        ST_GUARD
    } state_e;

    state_e                state_q, state_d;
    logic [ROUTE_BITS-1:0] idx_q, idx_d;
    logic                  hdr_q, hdr_d;
    logic [EG_W-1:0]       request_q, request_d;
    logic [EG_W-1:0]       write_q, write_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic [GCW-1:0]        guard_cnt_q, guard_cnt_d;

    logic                  ren;
    logic [ROUTE_BITS-1:0] head_idx;
    logic                  head_stop;
    logic [FLIT_WIDTH-1:0] head_rewr;
    logic [EG_W-1:0]       idx_onehot;
    logic                  sel_grant;
    logic                  sel_afull;

    always_comb begin
        head_idx   = bus.rdata[ROUTE_BITS-1:0];
        head_stop  = bus.rdata[FLIT_WIDTH-1];
        // next hop sees its own route field in the low bits
        head_rewr  = {head_stop, bus.rdata[PAYLOAD_WIDTH-1:0] >> ROUTE_BITS};
        idx_onehot = EG_W'(1) << idx_q;
        sel_grant  = |(bus.from_egress_grant & idx_onehot);
        sel_afull  = |(bus.from_egress_afull & idx_onehot);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hdr_d        = hdr_q;
        request_d    = request_q;
        write_d      = '0;
        data_d       = data_q;
        drop_count_d = drop_count_q;
        guard_cnt_d  = guard_cnt_q;
        ren          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.rempty) begin
                    idx_d = head_idx;
                    if ({1'b0, head_idx} < NB_EGRESS) begin
                        request_d = EG_W'(1) << head_idx;
                        hdr_d     = 1'b1;
                        state_d   = ST_SEND;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_SEND: begin
                ren = !bus.rempty && sel_grant && !sel_afull;
                if (ren) begin
                    write_d = idx_onehot;
                    data_d  = hdr_q ? head_rewr : bus.rdata;
                    hdr_d   = 1'b0;
                    if (head_stop) begin
                        request_d   = '0;
                        guard_cnt_d = GCW'(GUARD_CYCLES);
                        state_d     = ST_GUARD;
                    end
                end
            end
            ST_DROP: begin
                ren = !bus.rempty;
                if (ren && head_stop) begin
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q <= GCW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - GCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge router_clk or negedge router_arst_n) begin
        if (!router_arst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            hdr_q        <= 1'b0;
            request_q    <= '0;
            write_q      <= '0;
            data_q       <= '0;
            drop_count_q <= '0;
            guard_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hdr_q        <= hdr_d;
            request_q    <= request_d;
            write_q      <= write_d;
            data_q       <= data_d;
            drop_count_q <= drop_count_d;
            guard_cnt_q  <= guard_cnt_d;
        end
    end

    assign bus.ren               = ren;
    assign bus.to_egress_request = request_q;
    assign bus.to_egress_write   = write_q;
    assign bus.to_egress_data    = data_q;
    assign drop_count            = drop_count_q;
endmodule

// File: tb/tb_hynoc_ingress_ctrl.sv
// Bench for hynoc_ingress_ctrl: one 5-port and one 6-port instance fed from
// queue-modelled FWFT FIFOs, with an expected-write scoreboard per instance.
module tb_hynoc_ingress_ctrl;
    localparam int G = 2;

    logic router_clk = 1'b0;
    logic router_arst_n;
    always #5 router_clk = ~router_clk;

    hynoc_ingress_ctrl_if #(.NB_PORTS(5), .PAYLOAD_WIDTH(32)) bus5 ();
    hynoc_ingress_ctrl_if #(.NB_PORTS(6), .PAYLOAD_WIDTH(32)) bus6 ();
    logic [15:0] drop5;
    logic [15:0] drop6;

    hynoc_ingress_ctrl #(.NB_PORTS(5), .PAYLOAD_WIDTH(32), .GUARD_CYCLES(G)) u_dut5 (
        .router_clk    (router_clk),
        .router_arst_n (router_arst_n),
        .bus           (bus5),
        .drop_count    (drop5)
    );

    hynoc_ingress_ctrl #(.NB_PORTS(6), .PAYLOAD_WIDTH(32), .GUARD_CYCLES(G)) u_dut6 (
        .router_clk    (router_clk),
        .router_arst_n (router_arst_n),
        .bus           (bus6),
        .drop_count    (drop6)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] fifo5[$];
    logic [32:0] fifo6[$];
    logic [36:0] exp5[$];
    logic [37:0] exp6[$];
    logic        ren5_s = 1'b0;
    logic        ren6_s = 1'b0;

    always @(negedge router_clk) begin
        ren5_s = bus5.ren;
        ren6_s = bus6.ren;
    end

    // FWFT FIFO models: pop on the edge where the DUT saw ren high
    always @(posedge router_clk) begin
        #1;
        if (ren5_s && router_arst_n && fifo5.size() > 0) void'(fifo5.pop_front());
        if (ren6_s && router_arst_n && fifo6.size() > 0) void'(fifo6.pop_front());
        bus5.rempty = (fifo5.size() == 0);
        bus5.rdata  = (fifo5.size() > 0) ? fifo5[0] : 33'd0;
        bus6.rempty = (fifo6.size() == 0);
        bus6.rdata  = (fifo6.size() > 0) ? fifo6[0] : 33'd0;
    end

    always @(negedge router_clk) begin
        logic [36:0] e5;
        logic [37:0] e6;
        if (bus5.to_egress_write != 4'd0) begin
            n_checks++;
            if (exp5.size() == 0) begin
                n_fail++;
                $display("FAIL wr5_unexpected: got write=%b data=%h, required no write",
                         bus5.to_egress_write, bus5.to_egress_data);
            end else begin
                e5 = exp5.pop_front();
                if ({bus5.to_egress_write, bus5.to_egress_data} !== e5) begin
                    n_fail++;
                    $display("FAIL wr5_flit: got write=%b data=%h, required write=%b data=%h",
                             bus5.to_egress_write, bus5.to_egress_data, e5[36:33], e5[32:0]);
                end
            end
        end
        if (bus6.to_egress_write != 5'd0) begin
            n_checks++;
            if (exp6.size() == 0) begin
                n_fail++;
                $display("FAIL wr6_unexpected: got write=%b data=%h, required no write",
                         bus6.to_egress_write, bus6.to_egress_data);
            end else begin
                e6 = exp6.pop_front();
                if ({bus6.to_egress_write, bus6.to_egress_data} !== e6) begin
                    n_fail++;
                    $display("FAIL wr6_flit: got write=%b data=%h, required write=%b data=%h",
                             bus6.to_egress_write, bus6.to_egress_data, e6[37:33], e6[32:0]);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge router_clk);
        n_checks++;
        if ({bus5.to_egress_request, bus5.to_egress_write, bus5.to_egress_data, bus5.ren, drop5} !== 58'd0) begin
            n_fail++;
            $display("FAIL reset5_outputs: got %h, required 0",
                     {bus5.to_egress_request, bus5.to_egress_write, bus5.to_egress_data, bus5.ren, drop5});
        end
        n_checks++;
        if ({bus6.to_egress_request, bus6.to_egress_write, bus6.to_egress_data, bus6.ren, drop6} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset6_outputs: got %h, required 0",
                     {bus6.to_egress_request, bus6.to_egress_write, bus6.to_egress_data, bus6.ren, drop6});
        end
        @(posedge router_clk); #2;
        router_arst_n = 1'b1;
        repeat (3) @(negedge router_clk);
        n_checks++;
        if ({bus5.to_egress_request, bus5.ren} !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_empty: got request=%b ren=%b, required 0000/0",
                     bus5.to_egress_request, bus5.ren);
        end
    endtask

    task automatic test_single_flit();
        @(posedge router_clk); #2;
        bus5.from_egress_grant = 4'b0100;
        fifo5.push_back(33'h1_0000000E);
        exp5.push_back({4'b0100, 33'h1_00000003});
        repeat (2) @(negedge router_clk);
        n_checks++;
        if (bus5.to_egress_request !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_req_t: got %b, required 0000", bus5.to_egress_request);
        end
        @(negedge router_clk);
        n_checks++;
        if ({bus5.to_egress_request, bus5.ren} !== 5'b0100_1) begin
            n_fail++;
            $display("FAIL single_req_t1: got request=%b ren=%b, required 0100/1",
                     bus5.to_egress_request, bus5.ren);
        end
        @(negedge router_clk);
        n_checks++;
        if ({bus5.to_egress_request, bus5.to_egress_write} !== 8'b0000_0100) begin
            n_fail++;
            $display("FAIL single_drop_req: got request=%b write=%b, required 0000/0100",
                     bus5.to_egress_request, bus5.to_egress_write);
        end
        repeat (4) @(negedge router_clk);
        n_checks++;
        if (exp5.size() != 0) begin
            n_fail++;
            $display("FAIL single_pending: got %0d outstanding writes, required 0", exp5.size());
        end
        bus5.from_egress_grant = 4'b0000;
    endtask

    task automatic test_afull();
        logic prev_af;
        int   wcnt;
        prev_af = 1'b0;
        wcnt    = 0;
        @(posedge router_clk); #2;
        bus5.from_egress_grant = 4'b0010;
        fifo5.push_back(33'h0_12345675);
        fifo5.push_back(33'h0_AAAA0001);
        fifo5.push_back(33'h0_BBBB0002);
        fifo5.push_back(33'h1_CCCC0003);
        exp5.push_back({4'b0010, 33'h0_048D159D});
        exp5.push_back({4'b0010, 33'h0_AAAA0001});
        exp5.push_back({4'b0010, 33'h0_BBBB0002});
        exp5.push_back({4'b0010, 33'h1_CCCC0003});
        for (int k = 0; k < 20; k++) begin
            @(posedge router_clk); #2;
            bus5.from_egress_afull = (k >= 3 && k <= 5) ? 4'b0010 : 4'b0100;
            @(negedge router_clk);
            if (bus5.to_egress_write != 4'd0) wcnt++;
            if (bus5.from_egress_afull[1]) begin
                n_checks++;
                if (bus5.ren !== 1'b0) begin
                    n_fail++;
                    $display("FAIL afull_ren k=%0d: got ren=%b, required 0", k, bus5.ren);
                end
            end
            if (prev_af) begin
                n_checks++;
                if (bus5.to_egress_write !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL afull_write k=%0d: got write=%b, required 0000", k, bus5.to_egress_write);
                end
            end
            prev_af = bus5.from_egress_afull[1];
        end
        n_checks++;
        if (wcnt != 4 || exp5.size() != 0) begin
            n_fail++;
            $display("FAIL afull_count: got %0d writes, %0d outstanding, required 4 and 0", wcnt, exp5.size());
        end
        bus5.from_egress_afull = 4'b0000;
        bus5.from_egress_grant = 4'b0000;
    endtask

    task automatic test_grant_delay();
        @(posedge router_clk); #2;
        fifo5.push_back(33'h0_00000107);
        fifo5.push_back(33'h1_DEADBEEF);
        exp5.push_back({4'b1000, 33'h0_00000041});
        exp5.push_back({4'b1000, 33'h1_DEADBEEF});
        for (int k = 0; k < 16; k++) begin
            @(posedge router_clk); #2;
            bus5.from_egress_grant = (k >= 6) ? 4'b1001 : 4'b0001;
            @(negedge router_clk);
            if (k >= 1 && k <= 5) begin
                n_checks++;
                if ({bus5.to_egress_request, bus5.ren} !== 5'b1000_0) begin
                    n_fail++;
                    $display("FAIL gdelay_wait k=%0d: got request=%b ren=%b, required 1000/0",
                             k, bus5.to_egress_request, bus5.ren);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (bus5.ren !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gdelay_ren: got %b, required 1", bus5.ren);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (bus5.to_egress_write !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL gdelay_write: got %b, required 1000", bus5.to_egress_write);
                end
            end
        end
        n_checks++;
        if (exp5.size() != 0) begin
            n_fail++;
            $display("FAIL gdelay_pending: got %0d outstanding writes, required 0", exp5.size());
        end
        bus5.from_egress_grant = 4'b0000;
    endtask

    task automatic test_back_to_back();
        int         fall;
        int         rise;
        logic [3:0] prev;
        logic [3:0] rise_val;
        fall     = -1;
        rise     = -1;
        prev     = 4'b0000;
        rise_val = 4'b0000;
        @(posedge router_clk); #2;
        bus5.from_egress_grant = 4'b1001;
        fifo5.push_back(33'h0_00000010);
        fifo5.push_back(33'h1_00000055);
        fifo5.push_back(33'h1_0000FFFF);
        exp5.push_back({4'b0001, 33'h0_00000004});
        exp5.push_back({4'b0001, 33'h1_00000055});
        exp5.push_back({4'b1000, 33'h1_00003FFF});
        for (int k = 0; k < 25; k++) begin
            @(negedge router_clk);
            if (fall < 0 && prev == 4'b0001 && bus5.to_egress_request == 4'b0000) begin
                fall = k;
            end else if (fall >= 0 && rise < 0 && bus5.to_egress_request != 4'b0000) begin
                rise     = k;
                rise_val = bus5.to_egress_request;
            end
            prev = bus5.to_egress_request;
        end
        n_checks++;
        if (fall < 0 || rise - fall != G + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got fall=%0d rise=%0d, required rise-fall=%0d", fall, rise, G + 1);
        end
        n_checks++;
        if (rise_val !== 4'b1000) begin
            n_fail++;
            $display("FAIL b2b_req3: got %b, required 1000", rise_val);
        end
        n_checks++;
        if (exp5.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_pending: got %0d outstanding writes, required 0", exp5.size());
        end
        bus5.from_egress_grant = 4'b0000;
    endtask

    task automatic test_drop();
        int pops;
        int reqs;
        pops = 0;
        reqs = 0;
        @(posedge router_clk); #2;
        bus6.from_egress_grant = 5'b11111;
        fifo6.push_back(33'h0_00000006);
        fifo6.push_back(33'h0_11111111);
        fifo6.push_back(33'h1_22222222);
        @(posedge router_clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge router_clk);
            if (bus6.ren) pops++;
            if (bus6.to_egress_request != 5'd0) reqs++;
            if (k <= 1) begin
                n_checks++;
                if (bus6.ren !== (k == 1)) begin
                    n_fail++;
                    $display("FAIL drop_ren k=%0d: got %b, required %b", k, bus6.ren, (k == 1));
                end
            end
        end
        n_checks++;
        if (reqs != 0 || pops != 3) begin
            n_fail++;
            $display("FAIL drop_activity: got %0d request cycles, %0d pops, required 0 and 3", reqs, pops);
        end
        n_checks++;
        if (drop6 !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_count: got %0d, required 1", drop6);
        end
        @(posedge router_clk); #2;
        fifo6.push_back(33'h1_000000A4);
        exp6.push_back({5'b10000, 33'h1_00000014});
        repeat (8) @(negedge router_clk);
        n_checks++;
        if (exp6.size() != 0 || drop6 !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_next_pkt: got %0d outstanding, drop_count=%0d, required 0 and 1",
                     exp6.size(), drop6);
        end
        bus6.from_egress_grant = 5'b00000;
    endtask

    task automatic test_reset_mid();
        int seen;
        int k;
        seen = 0;
        k    = 0;
        @(posedge router_clk); #2;
        bus5.from_egress_grant = 4'b0100;
        fifo5.push_back(33'h0_00000002);
        fifo5.push_back(33'h0_10101010);
        fifo5.push_back(33'h0_20202020);
        fifo5.push_back(33'h1_30303030);
        exp5.push_back({4'b0100, 33'h0_00000000});
        exp5.push_back({4'b0100, 33'h0_10101010});
        exp5.push_back({4'b0100, 33'h0_20202020});
        exp5.push_back({4'b0100, 33'h1_30303030});
        while (seen == 0 && k < 12) begin
            @(negedge router_clk);
            if (bus5.to_egress_write != 4'd0) seen = 1;
            k++;
        end
        n_checks++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL rstmid_started: got no write in %0d cycles, required a write", k);
        end
        @(posedge router_clk); #3;
        router_arst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus5.to_egress_request, bus5.to_egress_write, bus5.to_egress_data, bus5.ren} !== 42'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got request=%b write=%b data=%h ren=%b, required all 0",
                     bus5.to_egress_request, bus5.to_egress_write, bus5.to_egress_data, bus5.ren);
        end
        fifo5.delete();
        exp5.delete();
        repeat (2) @(posedge router_clk);
        #2;
        router_arst_n = 1'b1;
        repeat (3) @(negedge router_clk);
        n_checks++;
        if ({bus5.to_egress_request, bus5.ren, drop6} !== 21'd0) begin
            n_fail++;
            $display("FAIL rstmid_release: got request=%b ren=%b drop_count6=%0d, required 0",
                     bus5.to_egress_request, bus5.ren, drop6);
        end
        @(posedge router_clk); #2;
        fifo5.push_back(33'h1_00000012);
        exp5.push_back({4'b0100, 33'h1_00000004});
        repeat (8) @(negedge router_clk);
        n_checks++;
        if (exp5.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_recover: got %0d outstanding writes, required 0", exp5.size());
        end
        bus5.from_egress_grant = 4'b0000;
    endtask

    initial begin
        router_arst_n          = 1'b0;
        bus5.rdata             = '0;
        bus5.rempty            = 1'b1;
        bus5.from_egress_grant = '0;
        bus5.from_egress_afull = '0;
        bus6.rdata             = '0;
        bus6.rempty            = 1'b1;
        bus6.from_egress_grant = '0;
        bus6.from_egress_afull = '0;
        test_reset();
        test_single_flit();
        test_afull();
        test_grant_delay();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
